// File: rtl/rv_wb_arbiter_if.sv
// -----------------------------------------------------------------------------
// rv_wb_arbiter_if
// Bundle of every signal that crosses the rv_wb_arbiter boundary apart from
// clock and reset: the fetch requester port (i_f_* / o_f_*), the data
// requester port (i_d_* / o_d_*) and the shared Wishbone master port
// (o_wb_* / i_wb_*). Names carry the direction as seen from the arbiter.
//   modport master : the arbiter's view (it is the Wishbone master)
//   modport slave  : the environment's view (requesters plus Wishbone slave)
// -----------------------------------------------------------------------------
interface rv_wb_arbiter_if;
   // fetch requester
   logic        i_f_req;
   logic [31:0] i_f_adr;
   logic        o_f_ack;
   logic        o_f_err;
   logic [31:0] o_f_rdata;
   // data requester
   logic        i_d_req;
   logic [31:0] i_d_adr;
   logic [31:0] i_d_wdata;
   logic        i_d_we;
   logic [3:0]  i_d_sel;
   logic        o_d_ack;
   logic        o_d_err;
   logic [31:0] o_d_rdata;
   // Wishbone bus
   logic [31:0] o_wb_adr;
   logic [31:0] o_wb_dat;
   logic [31:0] i_wb_dat;
   logic        o_wb_we;
   logic [3:0]  o_wb_sel;
   logic        o_wb_stb;
   logic        i_wb_ack;
   logic        o_wb_cyc;

   modport master (
      input  i_f_req, i_f_adr,
      output o_f_ack, o_f_err, o_f_rdata,
      input  i_d_req, i_d_adr, i_d_wdata, i_d_we, i_d_sel,
      output o_d_ack, o_d_err, o_d_rdata,
      output o_wb_adr, o_wb_dat, o_wb_we, o_wb_sel, o_wb_stb, o_wb_cyc,
      input  i_wb_dat, i_wb_ack
   );

   modport slave (
      output i_f_req, i_f_adr,
      input  o_f_ack, o_f_err, o_f_rdata,
      output i_d_req, i_d_adr, i_d_wdata, i_d_we, i_d_sel,
      input  o_d_ack, o_d_err, o_d_rdata,
      input  o_wb_adr, o_wb_dat, o_wb_we, o_wb_sel, o_wb_stb, o_wb_cyc,
      output i_wb_dat, i_wb_ack
   );
endinterface

// File: rtl/rv_wb_arbiter.sv
// -----------------------------------------------------------------------------
// rv_wb_arbiter
// Two-requester (instruction fetch / data load-store) arbiter in front of a
// single classic Wishbone master port. One transaction at a time; a round-
// robin pointer breaks ties when both requesters ask in the same idle cycle.
// Each bus cycle is guarded by an optional wait counter that terminates the
// cycle with a one-cycle error pulse if the slave never acknowledges.
//
// Ports:
//   i_clk          rising-edge clock
//   i_reset        synchronous active-high reset
//   bus (master)   fetch port, data port and Wishbone port, see
//                  rv_wb_arbiter_if
// Parameter:
//   TIMEOUT_CYCLES stb-high cycles to wait for i_wb_ack; 0 = wait forever
// -----------------------------------------------------------------------------
module rv_wb_arbiter #(
   parameter logic [15:0] TIMEOUT_CYCLES = 16'd255
) (
   input logic             i_clk,
   input logic             i_reset,
   rv_wb_arbiter_if.master bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUS_F = 2'd1,
      BUS_D = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic        last_d_q, last_d_d;   // 1: data port won the previous grant
   logic [15:0] wait_q, wait_d;
   logic [31:0] adr_q, adr_d;
   logic [31:0] dat_q, dat_d;
   logic        we_q, we_d;
   logic [3:0]  sel_q, sel_d;

   logic        in_bus;
   logic        grant_f;
   logic        grant_d;
   logic        acked;
   logic        timed_out;

   // Fetches are always word aligned; the low address bits are dropped.
   logic        f_adr_unused;
   assign f_adr_unused = ^bus.i_f_adr[1:0];

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q  <= IDLE;
         last_d_q <= 1'b1;            // so the first contended grant goes to fetch
         wait_q   <= 16'd0;
         adr_q    <= 32'd0;
         dat_q    <= 32'd0;
         we_q     <= 1'b0;
         sel_q    <= 4'd0;
      end else begin
         state_q  <= state_d;
         last_d_q <= last_d_d;
         wait_q   <= wait_d;
         adr_q    <= adr_d;
         dat_q    <= dat_d;
         we_q     <= we_d;
         sel_q    <= sel_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      in_bus    = (state_q != IDLE);
      // Round robin: on contention the port that did not win last time wins.
      grant_f   = (state_q == IDLE) && bus.i_f_req && (!bus.i_d_req || last_d_q);
      grant_d   = (state_q == IDLE) && bus.i_d_req && (!bus.i_f_req || !last_d_q);
      acked     = in_bus && bus.i_wb_ack;
      // An ack in the same cycle as the limit takes priority over the error.
      timed_out = in_bus && !bus.i_wb_ack && (TIMEOUT_CYCLES != 16'd0) &&
                  (wait_q == TIMEOUT_CYCLES);

      state_d  = state_q;
      last_d_d = last_d_q;
      wait_d   = wait_q;
      adr_d    = adr_q;
      dat_d    = dat_q;
      we_d     = we_q;
      sel_d    = sel_q;

      case (state_q)
         IDLE: begin
            if (grant_f) begin
               state_d  = BUS_F;
               last_d_d = 1'b0;
               wait_d   = 16'd0;
               adr_d    = {bus.i_f_adr[31:2], 2'b00};
               dat_d    = 32'd0;
               we_d     = 1'b0;
               sel_d    = 4'hF;
            end else if (grant_d) begin
               state_d  = BUS_D;
               last_d_d = 1'b1;
               wait_d   = 16'd0;
               adr_d    = bus.i_d_adr;
               dat_d    = bus.i_d_wdata;
               we_d     = bus.i_d_we;
               sel_d    = bus.i_d_sel;
            end
         end
         BUS_F, BUS_D: begin
            // Dropping to IDLE after every termination guarantees the idle
            // cycle between transactions, which is where arbitration happens.
            if (acked || timed_out) begin
               state_d = IDLE;
            end else begin
               wait_d  = wait_q + 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Output logic
   // ---------------------------------------------------------------------------
   always_comb begin
      bus.o_wb_adr  = adr_q;
      bus.o_wb_dat  = dat_q;
      bus.o_wb_we   = we_q;
      bus.o_wb_sel  = sel_q;
      bus.o_wb_stb  = in_bus;
      bus.o_wb_cyc  = in_bus;

      // Reset masks the handshake so a transaction killed by reset is silent.
      bus.o_f_ack   = bus.i_wb_ack && bus.o_wb_stb && (state_q == BUS_F) && !i_reset;
      bus.o_d_ack   = bus.i_wb_ack && bus.o_wb_stb && (state_q == BUS_D) && !i_reset;
      bus.o_f_err   = timed_out && (state_q == BUS_F) && !i_reset;
      bus.o_d_err   = timed_out && (state_q == BUS_D) && !i_reset;

      bus.o_f_rdata = (state_q == BUS_F) ? bus.i_wb_dat : 32'd0;
      bus.o_d_rdata = (state_q == BUS_D) ? bus.i_wb_dat : 32'd0;
   end

endmodule

// File: tb/tb_rv_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rv_wb_arbiter
// Directed scenarios followed by a randomized run for rv_wb_arbiter. A
// transaction-level reference model tracks the open bus transaction (owner,
// captured request fields, first-strobe cycle number) and predicts every
// cycle's outputs from it.
// -----------------------------------------------------------------------------
module tb_rv_wb_arbiter;

   localparam logic [15:0] TO = 16'd4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   rv_wb_arbiter_if bus ();

   rv_wb_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   typedef struct {
      bit          active;
      bit          is_d;
      logic [31:0] adr;
      logic [31:0] dat;
      logic        we;
      logic [3:0]  sel;
      int          start;     // cycle number of the first strobe cycle
   } txn_t;

   int   total = 0;
   int   bad   = 0;
   txn_t cur;
   bit   last_d;
   bit   zero_fields;          // bus fields must read 0 (after reset, before a grant)
   int   cyc = 0;
   int   grant_log[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Check the current cycle against the model, then advance one clock and
   // update the model from the inputs that were present at that edge.
   task automatic step();
      bit          ack;
      bit          to_hit;
      bit          pick_d;
      logic [31:0] f_adr;
      #2;
      ack    = (bus.i_wb_ack === 1'b1);
      to_hit = cur.active && !ack && !rst && (TO != 16'd0) && ((cyc - cur.start) == int'(TO));
      chk("stb",     32'(bus.o_wb_stb), 32'(cur.active));
      chk("cyc",     32'(bus.o_wb_cyc), 32'(cur.active));
      chk("f_ack",   32'(bus.o_f_ack),  32'(cur.active && !cur.is_d && ack && !rst));
      chk("d_ack",   32'(bus.o_d_ack),  32'(cur.active &&  cur.is_d && ack && !rst));
      chk("f_err",   32'(bus.o_f_err),  32'(to_hit && !cur.is_d));
      chk("d_err",   32'(bus.o_d_err),  32'(to_hit &&  cur.is_d));
      chk("f_rdata", bus.o_f_rdata, (cur.active && !cur.is_d) ? bus.i_wb_dat : 32'd0);
      chk("d_rdata", bus.o_d_rdata, (cur.active &&  cur.is_d) ? bus.i_wb_dat : 32'd0);
      if (cur.active) begin
         chk("wb_adr", bus.o_wb_adr,     cur.adr);
         chk("wb_dat", bus.o_wb_dat,     cur.dat);
         chk("wb_we",  32'(bus.o_wb_we),  32'(cur.we));
         chk("wb_sel", 32'(bus.o_wb_sel), 32'(cur.sel));
      end else if (zero_fields) begin
         chk("rst_adr", bus.o_wb_adr, 32'd0);
         chk("rst_dat", bus.o_wb_dat, 32'd0);
         chk("rst_we",  32'(bus.o_wb_we),  32'd0);
         chk("rst_sel", 32'(bus.o_wb_sel), 32'd0);
      end
      @(posedge clk);
      cyc++;
      if (rst) begin
         cur.active  = 1'b0;
         last_d      = 1'b1;
         zero_fields = 1'b1;
      end else if (cur.active) begin
         if (ack || to_hit) cur.active = 1'b0;
      end else if (bus.i_f_req || bus.i_d_req) begin
         pick_d      = bus.i_d_req && (!bus.i_f_req || !last_d);
         f_adr       = bus.i_f_adr;
         cur.active  = 1'b1;
         cur.is_d    = pick_d;
         cur.adr     = pick_d ? bus.i_d_adr   : {f_adr[31:2], 2'b00};
         cur.dat     = pick_d ? bus.i_d_wdata : 32'd0;
         cur.we      = pick_d ? bus.i_d_we    : 1'b0;
         cur.sel     = pick_d ? bus.i_d_sel   : 4'hF;
         cur.start   = cyc;
         last_d      = pick_d;
         zero_fields = 1'b0;
      end
      #1;
   endtask

   initial begin
      cur = '{active: 1'b0, is_d: 1'b0, adr: 32'd0, dat: 32'd0, we: 1'b0, sel: 4'd0, start: 0};
      last_d      = 1'b1;
      zero_fields = 1'b0;
      rst           = 1'b1;
      bus.i_f_req   = 1'b0;
      bus.i_f_adr   = 32'd0;
      bus.i_d_req   = 1'b0;
      bus.i_d_adr   = 32'd0;
      bus.i_d_wdata = 32'd0;
      bus.i_d_we    = 1'b0;
      bus.i_d_sel   = 4'd0;
      bus.i_wb_dat  = 32'd0;
      bus.i_wb_ack  = 1'b0;

      // reset state
      @(posedge clk); #1;
      step();
      rst = 1'b0;
      step();

      // stray ack while idle
      bus.i_wb_ack = 1'b1;
      step();
      step();
      bus.i_wb_ack = 1'b0;

      // fetch only, word-aligned address, one wait state, req dropped mid-way
      bus.i_f_req = 1'b1;
      bus.i_f_adr = 32'h0000_0103;
      step();
      bus.i_f_req = 1'b0;
      step();
      bus.i_wb_ack = 1'b1;
      bus.i_wb_dat = 32'h1234_5678;
      #1;
      chk("fetch_adr",   bus.o_wb_adr, 32'h0000_0100);
      chk("fetch_sel",   32'(bus.o_wb_sel), 32'hF);
      chk("fetch_ack",   32'(bus.o_f_ack), 32'd1);
      chk("fetch_rdata", bus.o_f_rdata, 32'h1234_5678);
      step();
      bus.i_wb_ack = 1'b0;
      step();

      // zero-wait store
      bus.i_d_req   = 1'b1;
      bus.i_d_adr   = 32'h0000_2002;
      bus.i_d_we    = 1'b1;
      bus.i_d_sel   = 4'b1100;
      bus.i_d_wdata = 32'hABCD_0000;
      step();
      bus.i_d_req  = 1'b0;
      bus.i_wb_ack = 1'b1;
      #1;
      chk("store_ack", 32'(bus.o_d_ack), 32'd1);
      chk("store_dat", bus.o_wb_dat, 32'hABCD_0000);
      chk("store_we",  32'(bus.o_wb_we), 32'd1);
      step();
      bus.i_wb_ack = 1'b0;
      #1;
      chk("store_cyc_low", 32'(bus.o_wb_cyc), 32'd0);
      step();

      // contention right after reset: F, D, F, D
      rst = 1'b1;
      step();
      rst = 1'b0;
      bus.i_f_req  = 1'b1;
      bus.i_d_req  = 1'b1;
      bus.i_wb_ack = 1'b1;
      grant_log.delete();
      for (int i = 0; i < 8; i++) begin
         #1;
         if (bus.o_f_ack) grant_log.push_back(0);
         else if (bus.o_d_ack) grant_log.push_back(1);
         step();
      end
      chk("rr_count", 32'(grant_log.size()), 32'd4);
      for (int i = 0; i < grant_log.size(); i++)
         chk("rr_order", 32'(grant_log[i]), 32'(i % 2));
      bus.i_f_req  = 1'b0;
      bus.i_d_req  = 1'b0;
      bus.i_wb_ack = 1'b0;
      step();

      // timeout with a silent slave, then ack on the limit cycle
      bus.i_d_req = 1'b1;
      step();
      bus.i_d_req = 1'b0;
      for (int i = 0; i < 4; i++) step();
      #1;
      chk("to_err", 32'(bus.o_d_err), 32'd1);
      step();
      #1;
      chk("to_cyc_drop", 32'(bus.o_wb_cyc), 32'd0);
      step();
      bus.i_d_req = 1'b1;
      step();
      bus.i_d_req = 1'b0;
      for (int i = 0; i < 4; i++) step();
      bus.i_wb_ack = 1'b1;
      #1;
      chk("to_ack_wins", 32'(bus.o_d_ack), 32'd1);
      chk("to_no_err",   32'(bus.o_d_err), 32'd0);
      step();
      bus.i_wb_ack = 1'b0;
      step();

      // reset in the middle of a fetch with the slave acking
      bus.i_f_req = 1'b1;
      bus.i_f_adr = 32'h0000_0444;
      step();
      bus.i_f_req = 1'b0;
      step();
      bus.i_wb_ack = 1'b1;
      rst = 1'b1;
      #1;
      chk("rst_no_ack", 32'(bus.o_f_ack), 32'd0);
      step();
      rst = 1'b0;
      bus.i_wb_ack = 1'b0;
      #1;
      chk("rst_stb", 32'(bus.o_wb_stb), 32'd0);
      chk("rst_adr_zero", bus.o_wb_adr, 32'd0);
      step();

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         rst           = ($urandom_range(0, 149) == 0);
         bus.i_f_req   = ($urandom_range(0, 2) != 0);
         bus.i_d_req   = ($urandom_range(0, 2) != 0);
         bus.i_f_adr   = $urandom;
         bus.i_d_adr   = $urandom;
         bus.i_d_wdata = $urandom;
         bus.i_d_we    = 1'($urandom_range(0, 1));
         bus.i_d_sel   = 4'($urandom_range(0, 15));
         bus.i_wb_dat  = $urandom;
         bus.i_wb_ack  = ($urandom_range(0, 3) == 0);
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rv_wb_arbiter.md
RV_WB_ARBITER -- requirements
Module: rv_wb_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with the ports named as listed below.
REQ-002 Parameter TIMEOUT_CYCLES, default 16'd255: maximum wait, in cycles with stb high, for i_wb_ack; 0 disables the timeout.
REQ-003 Ports:
- i_clk  in  1  rising-edge clock
- i_reset  in  1  synchronous active-high reset
- i_f_req  in  1  fetch request
- i_f_adr  in  32  fetch address; bits [1:0] ignored
- o_f_ack  out  1  fetch transaction done
- o_f_err  out  1  fetch timeout
- o_f_rdata  out  32  fetch read data
- i_d_req  in  1  data (load/store) request
- i_d_adr  in  32  data address
- i_d_wdata  in  32  store data, already lane-shuffled
- i_d_we  in  1  data write enable
- i_d_sel  in  4  data byte select
- o_d_ack  out  1  data transaction done
- o_d_err  out  1  data timeout
- o_d_rdata  out  32  data read data
- o_wb_adr  out  32  Wishbone address
- o_wb_dat  out  32  Wishbone write data
- i_wb_dat  in  32  Wishbone read data
- o_wb_we  out  1  Wishbone write enable
- o_wb_sel  out  4  Wishbone byte select
- o_wb_stb  out  1  Wishbone strobe
- i_wb_ack  in  1  Wishbone acknowledge
- o_wb_cyc  out  1  Wishbone cycle

Function
REQ-004 The block SHALL implement three states: IDLE, BUS_F and BUS_D.
REQ-005 In IDLE with exactly one request high, the block SHALL enter the matching BUS_x state on the next edge.
REQ-006 In IDLE with both requests high, the block SHALL grant the requester not recorded as last_grant (round-robin).
REQ-007 The block SHALL update last_grant on every grant.
REQ-008 On the grant edge, the block SHALL register the winner's adr/wdata/we/sel into o_wb_* and drive o_wb_cyc=o_wb_stb=1 from the next cycle onward.
REQ-009 For a fetch grant, the block SHALL force o_wb_adr={i_f_adr[31:2],2'b00}, o_wb_we=0, o_wb_sel=4'hF and o_wb_dat=0.
REQ-010 While in BUS_x, the block SHALL hold all o_wb_* outputs stable until termination.
REQ-011 o_x_ack SHALL equal i_wb_ack & o_wb_stb & (state==BUS_x) & !i_reset, combinationally.
REQ-012 o_x_rdata SHALL equal i_wb_dat while in BUS_x and 0 otherwise.
REQ-013 On an acked cycle, the block SHALL return to IDLE, deasserting cyc/stb on the next edge, so at least one idle cycle separates transactions.
REQ-014 Minimum latency: request high at cycle N, stb at N+1, ack to requester at N+1 when the slave acks immediately; back-to-back grants therefore occur every 2 cycles.
REQ-015 A requester deasserting req mid-transaction SHALL NOT abort the transaction; its ack still pulses.
REQ-016 The block SHALL ignore i_wb_ack outside BUS_x and produce no o_x_ack for it.
REQ-017 A 16-bit wait counter SHALL clear on grant and increment each BUS_x cycle without ack.
REQ-018 When TIMEOUT_CYCLES!=0 and the counter equals TIMEOUT_CYCLES without ack, the block SHALL pulse o_x_err for 1 cycle, drop cyc/stb on the next edge and return to IDLE.
REQ-019 If ack and timeout coincide, ack SHALL win and err SHALL stay 0.
REQ-020 o_f_ack/o_d_ack SHALL never be high together; likewise o_f_err/o_d_err.
REQ-021 A request arriving while the other requester is in BUS_x SHALL wait; it is granted in the next IDLE per REQ-005/006.

Reset
REQ-022 While i_reset=1 at an edge, the block SHALL set state=IDLE, last_grant=data, counter=0, o_wb_cyc=o_wb_stb=o_wb_we=0, o_wb_adr=o_wb_dat=0 and o_wb_sel=0.
REQ-023 When i_reset is asserted mid-transaction, the block SHALL drop cyc/stb at the reset edge and suppress acks and errs during the reset cycle; the transaction is lost.
REQ-024 The first contended grant after reset SHALL go to fetch.

Verification
REQ-025 Fetch-only: i_f_req=1, i_f_adr=0x103, slave acks 1 cycle after stb -> o_wb_adr=0x100, we=0, sel=F; o_f_ack pulses with o_f_rdata=i_wb_dat.
REQ-026 Store: i_d_req, adr=0x2002, we=1, sel=4'b1100, wdata=0xABCD0000, zero-wait ack -> ack at N+1; cyc low at N+2.
REQ-027 Contention: both requests held continuously, zero-wait slave -> grants alternate F,D,F,D beginning with F after reset.
REQ-028 Timeout: TIMEOUT_CYCLES=4, slave never acks -> o_d_err pulses once at stb cycle 5, cyc drops next edge; ack coinciding with that cycle yields ack, not err.
REQ-029 Reset mid-transaction: i_reset during BUS_F with i_wb_ack=1 -> no o_f_ack; all outputs 0 after the edge.
REQ-030 Stray ack: i_wb_ack=1 in IDLE -> no ack or err; state stays IDLE.
